// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core widths, x0 constant and ID/EX control field layout
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 2;

    localparam logic [RADDR_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic regwrite;
        logic memread;
    } ex_ctrl_t;

endpackage

// File: rtl/load_use_hazard.sv
// rtl/load_use_hazard.sv - combinational load-use detector between the ID instruction and the EX load
module load_use_hazard
    import riscv_pkg::*;
#(
    parameter int RADDR_W = riscv_pkg::RADDR_W
) (
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic               ex_valid,
    input  logic               ex_memread,
    input  logic [RADDR_W-1:0] ex_rd_addr,
    output logic               hazard
);

    logic ex_load_live;
    logic rs1_dep;
    logic rs2_dep;

    // A load into x0 produces nothing a consumer can depend on.
    assign ex_load_live = ex_valid && ex_memread && (ex_rd_addr != REG_X0);
    assign rs1_dep      = id_use_rs1 && (id_rs1_addr == ex_rd_addr);
    assign rs2_dep      = id_use_rs2 && (id_rs2_addr == ex_rd_addr);
    assign hazard       = id_valid && ex_load_live && (rs1_dep || rs2_dep);

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch with WB bypass, load-use bubbles and ID/EX register; OPFETCH_STALL_CNT_EN adds stall_cnt
module operand_fetch_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = riscv_pkg::XLEN,
    parameter int RADDR_W = riscv_pkg::RADDR_W,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic               id_regwrite,
    input  logic               id_memread,
    output logic [RADDR_W-1:0] rf_rs1_addr,
    output logic [RADDR_W-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]    rf_rs1,
    input  logic [XLEN-1:0]    rf_rs2,
    input  logic               wb_regwrite,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_rs1_val,
    output logic [XLEN-1:0]    ex_rs2_val,
    output logic [RADDR_W-1:0] ex_rs1_addr,
    output logic [RADDR_W-1:0] ex_rs2_addr,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_regwrite,
    output logic               ex_memread
`ifdef OPFETCH_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt
`endif
);

    logic            hazard;
    logic            advance;
    logic            wb_live;
    logic            wb_hit1;
    logic            wb_hit2;
    logic            refresh1;
    logic            refresh2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    ex_ctrl_t        ctrl_q;

    assign rf_rs1_addr = id_rs1_addr;
    assign rf_rs2_addr = id_rs2_addr;

    load_use_hazard #(
        .RADDR_W (RADDR_W)
    ) u_hazard (
        .id_valid    (id_valid),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_valid    (ex_valid),
        .ex_memread  (ctrl_q.memread),
        .ex_rd_addr  (ex_rd_addr),
        .hazard      (hazard)
    );

    // The register file writes at the same edge we sample, so its read data is stale on a match.
    assign wb_live  = wb_regwrite && (wb_rd != REG_X0);
    assign wb_hit1  = wb_live && (wb_rd == id_rs1_addr);
    assign wb_hit2  = wb_live && (wb_rd == id_rs2_addr);
    assign op1      = wb_hit1 ? wb_data : rf_rs1;
    assign op2      = wb_hit2 ? wb_data : rf_rs2;

    // Held operands would miss a write-back that lands while EX is stalled.
    assign refresh1 = wb_live && (wb_rd == ex_rs1_addr);
    assign refresh2 = wb_live && (wb_rd == ex_rs2_addr);

    assign advance  = !ex_valid || ex_ready;
    assign id_ready = flush || (advance && !hazard);

    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_memread  = ctrl_q.memread;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ctrl_q      <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance && hazard) begin
            ex_valid <= 1'b0;
        end else if (advance) begin
            ex_valid        <= id_valid;
            ex_pc           <= id_pc;
            ex_imm          <= id_imm;
            ex_rs1_val      <= op1;
            ex_rs2_val      <= op2;
            ex_rs1_addr     <= id_rs1_addr;
            ex_rs2_addr     <= id_rs2_addr;
            ex_rd_addr      <= id_rd_addr;
            ctrl_q.regwrite <= id_regwrite;
            ctrl_q.memread  <= id_memread;
        end else begin
            if (refresh1) begin
                ex_rs1_val <= wb_data;
            end
            if (refresh2) begin
                ex_rs2_val <= wb_data;
            end
        end
    end

`ifdef OPFETCH_STALL_CNT_EN
    logic stall_event;

    assign stall_event = hazard && advance && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_event && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - vector table, directed corners and randomized model check of operand_fetch_stage
module tb_operand_fetch_stage;

    localparam int CW = 4;

    logic        clk;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1, rf_rs2;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic        ex_regwrite, ex_memread;
`ifdef OPFETCH_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    operand_fetch_stage #(.XLEN(32), .RADDR_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd_addr(id_rd_addr), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
`ifdef OPFETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: x0 never written, combinational read.
    logic [31:0] regs [32];
    assign rf_rs1 = regs[rf_rs1_addr];
    assign rf_rs2 = regs[rf_rs2_addr];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock; the register-file write is applied after the DUT has sampled.
    task automatic cycle();
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        we = wb_regwrite; wa = wb_rd; wd = wb_data;
        @(posedge clk);
        @(negedge clk);
        if (we && wa != 5'd0) regs[wa] = wd;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1_addr = r1; id_rs2_addr = r2; id_use_rs1 = u1;
        id_use_rs2 = u2; id_rd_addr = rd; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    typedef struct {
        logic v; logic [4:0] r1, r2; logic u1, u2; logic [4:0] rd; logic rw, mr;
        logic we; logic [4:0] wrd; logic [31:0] wd; logic rdy, fl;
        logic e_idr, e_val, e_pay; logic [31:0] e_r1, e_r2; logic [4:0] e_rd; int e_src;
    } vec_t;

    vec_t vecs [15];

    typedef struct {
        logic valid; logic [31:0] pc, imm, r1v, r2v; logic [4:0] r1a, r2a, rd; logic rw, mr;
    } ex_m_t;

    ex_m_t       m, mn;
    int          cnt_m;
    logic        hz, adv, exp_idr;
    logic [31:0] o1, o2;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000 + i;
        regs[3] = 32'h33; regs[5] = 32'h11; regs[7] = 32'h77;

        //           v r1 r2 u1 u2 rd rw mr  we wrd wd       rdy fl  idr val pay r1        r2        rd  src
        vecs[0]  = '{1, 5, 3, 1, 1, 1, 1, 0,  1, 5, 32'hAA,  1, 0,   1, 1, 1, 32'hAA,   32'h33,   1,  0};
        vecs[1]  = '{1, 0, 0, 1, 1, 0, 1, 0,  1, 0, 32'hBB,  1, 0,   1, 1, 1, 32'h0,    32'h0,    0,  1};
        vecs[2]  = '{1, 3, 0, 1, 0, 7, 1, 1,  0, 0, 32'h0,   1, 0,   1, 1, 1, 32'h33,   32'h0,    7,  2};
        vecs[3]  = '{1, 3, 7, 1, 1, 8, 1, 0,  0, 0, 32'h0,   1, 0,   0, 0, 0, 32'h0,    32'h0,    0,  3};
        vecs[4]  = '{1, 3, 7, 1, 1, 8, 1, 0,  0, 0, 32'h0,   1, 0,   1, 1, 1, 32'h33,   32'h77,   8,  4};
        vecs[5]  = '{1, 3, 0, 1, 0, 7, 1, 1,  0, 0, 32'h0,   1, 0,   1, 1, 1, 32'h33,   32'h0,    7,  5};
        vecs[6]  = '{1, 3, 7, 1, 0, 9, 1, 0,  0, 0, 32'h0,   1, 0,   1, 1, 1, 32'h33,   32'h77,   9,  6};
        vecs[7]  = '{1, 3, 4, 1, 1, 10, 1, 0, 0, 0, 32'h0,   1, 0,   1, 1, 1, 32'h33,   32'h1004, 10, 7};
        vecs[8]  = '{1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 32'h0,   0, 0,   0, 1, 1, 32'h33,   32'h1004, 10, 7};
        vecs[9]  = '{1, 1, 2, 1, 1, 11, 1, 0, 1, 3, 32'h55,  0, 0,   0, 1, 1, 32'h55,   32'h1004, 10, 7};
        vecs[10] = '{1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 32'h0,   0, 0,   0, 1, 1, 32'h55,   32'h1004, 10, 7};
        vecs[11] = '{1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 32'h0,   1, 0,   1, 1, 1, 32'h1001, 32'h1002, 11, 11};
        vecs[12] = '{1, 1, 0, 1, 0, 7, 1, 1,  0, 0, 32'h0,   1, 0,   1, 1, 1, 32'h1001, 32'h0,    7,  12};
        vecs[13] = '{1, 7, 0, 1, 0, 12, 1, 0, 0, 0, 32'h0,   0, 1,   1, 0, 0, 32'h0,    32'h0,    0,  13};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,   1, 0,   1, 0, 0, 32'h0,    32'h0,    0,  14};

        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        id_pc = '0; id_imm = '0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0; flush = 0; ex_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("reset_ex_pc", ex_pc, 32'h0);
        #1 rst = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            set_id(vecs[i].v, vecs[i].r1, vecs[i].r2, vecs[i].u1, vecs[i].u2,
                   vecs[i].rd, vecs[i].rw, vecs[i].mr);
            id_pc = 32'h100 + 32'(i * 4); id_imm = 32'(i);
            wb_regwrite = vecs[i].we; wb_rd = vecs[i].wrd; wb_data = vecs[i].wd;
            ex_ready = vecs[i].rdy; flush = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_id_ready", i), {31'b0, id_ready}, {31'b0, vecs[i].e_idr});
            cycle();
            chk($sformatf("v%0d_ex_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].e_val});
            if (vecs[i].e_pay) begin
                chk($sformatf("v%0d_rs1_val", i), ex_rs1_val, vecs[i].e_r1);
                chk($sformatf("v%0d_rs2_val", i), ex_rs2_val, vecs[i].e_r2);
                chk($sformatf("v%0d_rd", i), {27'b0, ex_rd_addr}, {27'b0, vecs[i].e_rd});
                chk($sformatf("v%0d_pc", i), ex_pc, 32'h100 + 32'(vecs[i].e_src * 4));
            end
        end

        // Reset asserted in the middle of a load-use stall
        set_id(1, 3, 0, 1, 0, 7, 1, 1); ex_ready = 1; flush = 0;
        wb_regwrite = 0;
        cycle();
        set_id(1, 7, 0, 1, 0, 8, 1, 0);
        #1 chk("mid_stall_id_ready", {31'b0, id_ready}, 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_ex_pc", ex_pc, 32'h0);
        chk("rst_ex_rs1_val", ex_rs1_val, 32'h0);
        chk("rst_ex_rd", {27'b0, ex_rd_addr}, 32'h0);
        chk("rst_ex_ctrl", {30'b0, ex_regwrite, ex_memread}, 32'h0);
        chk("rst_id_ready", {31'b0, id_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("post_rst_id_ready", {31'b0, id_ready}, 32'h1);
        cycle();
        chk("post_rst_ex_valid", {31'b0, ex_valid}, 32'h0);

        // Randomized run against the rule-level model
        pulse_reset();
        @(negedge clk);
        m = '{default: '0};
        cnt_m = 0;
        for (int c = 0; c < 600; c++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs1_addr = 5'($urandom_range(0, 7));
            id_rs2_addr = 5'($urandom_range(0, 7));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            id_rd_addr  = 5'($urandom_range(0, 7));
            id_regwrite = 1'($urandom_range(0, 1));
            id_memread  = ($urandom_range(0, 2) == 0);
            id_pc       = $urandom();
            id_imm      = $urandom();
            wb_regwrite = 1'($urandom_range(0, 1));
            wb_rd       = 5'($urandom_range(0, 7));
            wb_data     = $urandom();
            ex_ready    = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            #1;
            hz  = id_valid && m.valid && m.mr && m.rd != 0 &&
                  ((id_use_rs1 && id_rs1_addr == m.rd) || (id_use_rs2 && id_rs2_addr == m.rd));
            adv = !m.valid || ex_ready;
            exp_idr = flush || (adv && !hz);
            o1 = (wb_regwrite && wb_rd != 0 && wb_rd == id_rs1_addr) ? wb_data : regs[id_rs1_addr];
            o2 = (wb_regwrite && wb_rd != 0 && wb_rd == id_rs2_addr) ? wb_data : regs[id_rs2_addr];
            mn = m;
            if (flush || (adv && hz)) begin
                mn.valid = 1'b0;
            end else if (adv) begin
                mn = '{id_valid, id_pc, id_imm, o1, o2, id_rs1_addr, id_rs2_addr,
                       id_rd_addr, id_regwrite, id_memread};
            end else begin
                if (wb_regwrite && wb_rd != 0 && wb_rd == m.r1a) mn.r1v = wb_data;
                if (wb_regwrite && wb_rd != 0 && wb_rd == m.r2a) mn.r2v = wb_data;
            end
            if (hz && adv && !flush && cnt_m < (1 << CW) - 1) cnt_m++;
            chk("rnd_id_ready", {31'b0, id_ready}, {31'b0, exp_idr});
            chk("rnd_rf_addr", {22'b0, rf_rs1_addr, 5'b0, rf_rs2_addr},
                {22'b0, id_rs1_addr, 5'b0, id_rs2_addr});
            cycle();
            m = mn;
            chk("rnd_ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
            if (m.valid) begin
                chk("rnd_ex_pc", ex_pc, m.pc);
                chk("rnd_ex_imm", ex_imm, m.imm);
                chk("rnd_ex_rs1_val", ex_rs1_val, m.r1v);
                chk("rnd_ex_rs2_val", ex_rs2_val, m.r2v);
                chk("rnd_ex_addrs", {17'b0, ex_rs1_addr, ex_rs2_addr, ex_rd_addr},
                    {17'b0, m.r1a, m.r2a, m.rd});
                chk("rnd_ex_ctrl", {30'b0, ex_regwrite, ex_memread}, {30'b0, m.rw, m.mr});
            end
`ifdef OPFETCH_STALL_CNT_EN
            chk("rnd_stall_cnt", {28'b0, stall_cnt}, 32'(cnt_m));
`endif
        end

`ifdef OPFETCH_STALL_CNT_EN
        // Repeated load-use stalls: count to 4, then saturate at all-ones
        pulse_reset();
        @(negedge clk);
        flush = 0; ex_ready = 1; wb_regwrite = 0;
        for (int k = 0; k < 17; k++) begin
            set_id(1, 1, 0, 1, 0, 7, 1, 1);
            cycle();
            set_id(1, 7, 0, 1, 0, 8, 1, 0);
            cycle();
            cycle();
            if (k == 3) chk("stall_cnt_4", {28'b0, stall_cnt}, 32'd4);
        end
        chk("stall_cnt_sat", {28'b0, stall_cnt}, 32'd15);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-side neighbour of the register file in the pipelined RISC-V core.
- Drives the register file read addresses and takes its combinational read data.
- Bypasses the same-cycle write-back value, detects load-use hazards and inserts bubbles.
- Holds the ID/EX pipeline register with a valid/ready handshake to EX and a flush from branch resolution.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register address width.
- CNT_W, 32, stall-counter width (optional feature only).

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decoded instruction present.
- id_ready  out  1  stage accepts the instruction this cycle.
- id_pc  in  XLEN  instruction PC.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1_addr, id_rs2_addr  in  RADDR_W  source registers.
- id_use_rs1, id_use_rs2  in  1  source actually read.
- id_rd_addr  in  RADDR_W  destination.
- id_regwrite, id_memread  in  1  control bits.
- rf_rs1_addr, rf_rs2_addr  out  RADDR_W  to register file (equal to id_rs*_addr).
- rf_rs1, rf_rs2  in  XLEN  register file read data (x0 reads 0).
- wb_regwrite  in  1  write-back enable, same signal driving the register file.
- wb_rd  in  RADDR_W  write-back address.
- wb_data  in  XLEN  write-back data.
- flush  in  1  kill the ID instruction and the EX register contents.
- ex_valid  out  1  ID/EX register holds a live instruction.
- ex_ready  in  1  EX consumes it this cycle.
- ex_pc, ex_imm, ex_rs1_val, ex_rs2_val  out  XLEN  registered payload.
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  RADDR_W  registered addresses.
- ex_regwrite, ex_memread  out  1  registered control.

Behaviour:
- Reset (rst=0, async): every ex_* output is cleared to 0, including ex_valid.
- Operand bypass: wb_hit1 = wb_regwrite & wb_rd!=0 & wb_rd==id_rs1_addr. Operand 1 = wb_hit1 ? wb_data : rf_rs1. Operand 2 uses the same rule.
- Load-use hazard:
  - hazard = id_valid & ex_valid & ex_memread & ex_rd_addr!=0 & ((id_use_rs1 & id_rs1_addr==ex_rd_addr) | (id_use_rs2 & id_rs2_addr==ex_rd_addr)).
  - A hazard costs exactly one bubble per load when EX is ready.
- advance = ~ex_valid | ex_ready.
- id_ready = flush | (advance & ~hazard). During flush the ID instruction is dropped.
- Clock edge priority:
  1. flush: ex_valid<=0; payload don't-care.
  2. advance & hazard: ex_valid<=0 (bubble); ID is not accepted.
  3. advance: ex_valid<=id_valid, and the payload loads from ID and the bypassed operands.
  4. Hold (ex_valid & ~ex_ready): payload is retained, except a write-back refresh. If wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1_addr, then ex_rs1_val<=wb_data. The same applies to rs2. This keeps held operands coherent across EX stalls.
- Latency: one cycle from ID acceptance to ex_valid.
- No combinational path from ex_ready to ex_* data. A path from ex_ready to id_ready is permitted.
- x0: never bypassed or refreshed; a hazard on rd=0 is ignored.
- A write-back to the same register on both rs1 and rs2 bypasses both.
- A reset mid-stall clears the bubble and hazard state immediately. The first post-reset cycle has ex_valid=0, so hazard=0.

Optional Feature:
- Macro: OPFETCH_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [CNT_W-1:0].
  - It increments on every cycle with hazard & advance & ~flush, and saturates at all-ones.
  - It clears on reset.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pkg: XLEN, RADDR_W, REG_X0 constant, and the ID/EX payload field widths.
- One natural sub-module, load_use_hazard: purely combinational, producing hazard from the id_* and ex_* fields.
- The bypass, handshake and ID/EX register stay in the top level.

Test Plan:
- Reset: rst=0 mid-stream with ex_valid=1 -> all ex_* outputs immediately 0; after release, id_ready=1 with ex_ready=1.
- Bypass: x5=0x11 in the register file, wb writes x5=0xAA the same cycle ID reads rs1=x5 -> next cycle ex_rs1_val=0xAA. A wb to x0 with rs1=x0 -> ex_rs1_val=0.
- Load-use: EX holds lw x7 (memread=1, rd=7), ID is add using rs2=x7 -> one cycle with id_ready=0 and ex_valid=0, then the add enters EX. The same case with id_use_rs2=0 -> no bubble.
- EX backpressure refresh: ex_ready=0 for 3 cycles with ex_rs1_addr=x3 and wb writing x3=0x55 in cycle 2 -> ex_rs1_val=0x55 while ex_valid stays 1; the payload is otherwise unchanged.
- Flush: flush=1 with a hazard pending and ex_ready=0 -> next cycle ex_valid=0, and id_ready=1 during the flush cycle.
- OPFETCH_STALL_CNT_EN: 4 load-use stalls -> stall_cnt=4. Preload near max with CNT_W=4 -> saturates at 15.
